// File: rtl/seg7.sv
// seg7 -- registered BCD-to-seven-segment decoder for one DE1-SoC HEX digit.
//
// Purpose:
//   Decodes a 4-bit digit code into the seven segment drive lines with a
//   fixed one-cycle latency. Codes 10-15 blank the digit unless the hex glyph
//   option is built in.
//
// Build option:
//   SEG7_HEX_EN  when defined, codes 10-15 show hex glyphs A b C d E F.
//
// Parameters:
//   ACTIVE_LOW   1: a lit segment drives 0 (DE1-SoC); 0: a lit segment drives 1.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high; loads the all-off pattern
//   bcd        digit code, sampled every edge
//   blank      1 forces all segments off
//   lamp_test  1 forces all segments on (beats blank)
//   leds       registered segment drive, leds[0]=a ... leds[6]=g
module seg7 #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] leds
);

  // Patterns below are all in active-low form (0 = segment lit).
  localparam logic [6:0] ALL_OFF = 7'b1111111;
  localparam logic [6:0] ALL_ON  = 7'b0000000;

  logic [6:0] glyph_n;     // decoded digit, active-low
  logic [6:0] sel_n;       // after lamp_test/blank priority, active-low
  logic [6:0] leds_next;   // after polarity adjustment
  logic [6:0] leds_reg;

  always_comb begin
    glyph_n = ALL_OFF;
    case (bcd)
      4'd0:  glyph_n = 7'b1000000;
      4'd1:  glyph_n = 7'b1111001;
      4'd2:  glyph_n = 7'b0100100;
      4'd3:  glyph_n = 7'b0110000;
      4'd4:  glyph_n = 7'b0011001;
      4'd5:  glyph_n = 7'b0010010;
      4'd6:  glyph_n = 7'b0000010;
      4'd7:  glyph_n = 7'b1111000;
      4'd8:  glyph_n = 7'b0000000;
      4'd9:  glyph_n = 7'b0010000;
`ifdef SEG7_HEX_EN
      4'd10: glyph_n = 7'b0001000;  // A
      4'd11: glyph_n = 7'b0000011;  // b
      4'd12: glyph_n = 7'b1000110;  // C
      4'd13: glyph_n = 7'b0100001;  // d
      4'd14: glyph_n = 7'b0000110;  // E
      4'd15: glyph_n = 7'b0001110;  // F
`else
      default: glyph_n = ALL_OFF;   // 10-15 blank the digit
`endif
    endcase
  end

  always_comb begin
    sel_n = glyph_n;
    if (lamp_test)
      sel_n = ALL_ON;
    else if (blank)
      sel_n = ALL_OFF;
  end

  // Polarity is applied per bit; the reset value goes through the same
  // mapping so it always means "all segments off".
  logic [6:0] off_pattern;
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_pol
      assign leds_next[gi]   = ACTIVE_LOW ? sel_n[gi]   : ~sel_n[gi];
      assign off_pattern[gi] = ACTIVE_LOW ? ALL_OFF[gi] : ~ALL_OFF[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      leds_reg <= off_pattern;
    else
      leds_reg <= leds_next;
  end

  assign leds = leds_reg;

endmodule

// File: tb/tb_seg7.sv
// tb_seg7 -- self-checking bench for seg7.
// Two instances share the stimulus: one active-low, one active-high. A model
// describes each glyph by the names of its lit segments and derives the drive
// pattern for either polarity; a compare process checks both instances every
// cycle, and the directed sequence also checks hand-computed literals.
module tb_seg7;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] leds_lo;
  logic [6:0] leds_hi;

  int total = 0;
  int bad   = 0;

  seg7 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank),
    .lamp_test(lamp_test), .leds(leds_lo)
  );

  seg7 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank),
    .lamp_test(lamp_test), .leds(leds_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  string glyph [16];

  initial begin
    glyph[0] = "abcdef";  glyph[1] = "bc";      glyph[2] = "abdeg";
    glyph[3] = "abcdg";   glyph[4] = "bcfg";    glyph[5] = "acdfg";
    glyph[6] = "acdefg";  glyph[7] = "abc";     glyph[8] = "abcdefg";
    glyph[9] = "abcdfg";
`ifdef SEG7_HEX_EN
    glyph[10] = "abcefg"; glyph[11] = "cdefg";  glyph[12] = "adef";
    glyph[13] = "bcdeg";  glyph[14] = "adefg";  glyph[15] = "aefg";
`else
    for (int i = 10; i < 16; i++) glyph[i] = "";
`endif
  end

  // Set of lit segments (bit k = segment 'a'+k) from a glyph name string.
  function automatic logic [6:0] lit_of(input string s);
    logic [6:0] m;
    m = '0;
    for (int i = 0; i < s.len(); i++) begin
      int k;
      k = int'(s.getc(i)) - 97;
      m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [6:0] model_lit(input logic r, input logic lt,
                                           input logic bl, input logic [3:0] d);
    if (r)  return 7'b0000000;
    if (lt) return 7'b1111111;
    if (bl) return 7'b0000000;
    return lit_of(glyph[d]);
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %07b required %07b at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [6:0] lit;
    lit = model_lit(reset, lamp_test, blank, bcd);
    #3;
    chk("model_lo", leds_lo, ~lit);
    chk("model_hi", leds_hi, lit);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic r, input logic lt, input logic bl, input logic [3:0] d);
    reset = r; lamp_test = lt; blank = bl; bcd = d;
    @(posedge clk);
    #2;
    $display("step reset=%0b lamp=%0b blank=%0b bcd=%0d -> lo=%07b hi=%07b",
             r, lt, bl, d, leds_lo, leds_hi);
  endtask

  logic [6:0] sweep_lo [16];

  initial begin
    sweep_lo[0] = 7'b1000000; sweep_lo[1] = 7'b1111001; sweep_lo[2] = 7'b0100100;
    sweep_lo[3] = 7'b0110000; sweep_lo[4] = 7'b0011001; sweep_lo[5] = 7'b0010010;
    sweep_lo[6] = 7'b0000010; sweep_lo[7] = 7'b1111000; sweep_lo[8] = 7'b0000000;
    sweep_lo[9] = 7'b0010000;
`ifdef SEG7_HEX_EN
    sweep_lo[10] = 7'b0001000; sweep_lo[11] = 7'b0000011; sweep_lo[12] = 7'b1000110;
    sweep_lo[13] = 7'b0100001; sweep_lo[14] = 7'b0000110; sweep_lo[15] = 7'b0001110;
`else
    for (int i = 10; i < 16; i++) sweep_lo[i] = 7'b1111111;
`endif

    reset = 1'b1; lamp_test = 1'b1; blank = 1'b0; bcd = 4'd8;

    // reset beats lamp_test
    step(1'b1, 1'b1, 1'b0, 4'd8);
    chk("reset1_lo", leds_lo, 7'b1111111);
    chk("reset1_hi", leds_hi, 7'b0000000);
    step(1'b1, 1'b1, 1'b0, 4'd8);
    chk("reset2_lo", leds_lo, 7'b1111111);
    step(1'b0, 1'b0, 1'b0, 4'd8);
    chk("release8_lo", leds_lo, 7'b0000000);

    // full sweep, one code per cycle
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'(i));
      chk($sformatf("sweep%0d_lo", i), leds_lo, sweep_lo[i]);
    end

    // blank, then release
    step(1'b0, 1'b0, 1'b1, 4'd5);
    chk("blank5_lo", leds_lo, 7'b1111111);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    chk("unblank5_lo", leds_lo, 7'b0010010);

    // lamp_test beats blank
    step(1'b0, 1'b1, 1'b1, 4'd1);
    chk("lamp_over_blank_lo", leds_lo, 7'b0000000);
    chk("lamp_over_blank_hi", leds_hi, 7'b1111111);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("blank_after_lamp_lo", leds_lo, 7'b1111111);

    // active-high instance
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("hi_bcd0", leds_hi, 7'b0111111);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("hi_reset", leds_hi, 7'b0000000);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("hi_lamp", leds_hi, 7'b1111111);

    // one-cycle reset in the middle of a sweep
    step(1'b0, 1'b0, 1'b0, 4'd2);
    chk("pre_reset_lo", leds_lo, 7'b0100100);
    step(1'b1, 1'b0, 1'b0, 4'd4);
    chk("mid_reset_lo", leds_lo, 7'b1111111);
    step(1'b0, 1'b0, 1'b0, 4'd6);
    chk("post_reset_lo", leds_lo, 7'b0000010);
    step(1'b0, 1'b0, 1'b0, 4'd7);
    chk("post_reset2_lo", leds_lo, 7'b1111000);
    chk("post_reset2_hi", leds_hi, 7'b0000111);

    @(posedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7.md
Name: seg7

Overview:
Registered BCD-to-seven-segment decoder for one DE1-SoC HEX digit. Takes a 4-bit digit code and drives the seven segment lines with a fixed one-cycle latency. Used by board-level wrappers that route switch or counter values to HEX0..HEX5. Codes 10-15 blank the digit by default; hex glyphs A-F are an optional build feature.

Parameters:
ACTIVE_LOW, 1, segment polarity. 1: a lit segment drives 0, as on the DE1-SoC. 0: a lit segment drives 1 (all output bits inverted).

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
bcd  input  4  digit code to display, sampled every clk edge
blank  input  1  1 forces all segments off
lamp_test  input  1  1 forces all segments on
leds  output  7  segment drive: leds[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g; registered

Behaviour:
- One clock, one register stage on leds. No combinational path from any input to leds.
- Latency: inputs sampled at edge N appear on leds after edge N and hold until the next edge.
- Reset is synchronous and active-high. The edge with reset=1 loads the all-off pattern (7'b1111111 when ACTIVE_LOW=1). reset=1 mid-operation blanks the digit on that edge regardless of the other inputs.
- Priority at each edge, highest first: reset, lamp_test, blank, bcd decode.
  - lamp_test=1: all segments lit (7'b0000000 when ACTIVE_LOW=1).
  - blank=1 (lamp_test=0): all segments off.
- Decode table, active-low form (leds[6:0], g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Codes 10-15: all segments off (1111111), unless SEG7_HEX_EN is defined.
- ACTIVE_LOW=0: every pattern above, including the reset, blank and lamp-test patterns, is bitwise inverted before registering.
- bcd containing X/Z at a sampling edge: output treated as don't-care; benches must not rely on it.
- No internal state beyond the output register. Back-to-back changes of bcd on consecutive cycles are each reflected one cycle later.

Optional Feature:
- Macro SEG7_HEX_EN.
- When defined: codes 10-15 decode to hex glyphs, active-low form:
  - A=0001000, b=0000011, C=1000110
  - d=0100001, E=0000110, F=0001110
  - Same priority, latency and polarity rules apply.
- When undefined: codes 10-15 produce all segments off, and no hex glyph logic is present.

Test Plan:
- reset=1 for 2 cycles with bcd=8 and lamp_test=1 -> leds=1111111 after each edge. Release reset with bcd=8, lamp_test=0, blank=0 -> leds=0000000 one edge later.
- Sweep bcd 0..15, one value per cycle, blank=lamp_test=0 -> leds follows the decode table with 1-cycle lag (e.g. bcd=3 at edge N gives 0110000 after edge N).
  - Without SEG7_HEX_EN: 10..15 give 1111111.
  - With SEG7_HEX_EN: 10 gives 0001000, 15 gives 0001110.
- bcd=5, blank=1 -> 1111111. Then blank=0 -> 0010010 on the next edge.
- bcd=1, blank=1, lamp_test=1 -> 0000000 (lamp_test wins). Drop lamp_test -> 1111111 (blank still set).
- ACTIVE_LOW=0 instance: bcd=0 -> 0111111; reset -> 0000000; lamp_test -> 1111111.
- Assert reset for one cycle while sweeping bcd -> exactly that one cycle shows 1111111. The next cycle shows the decode of the bcd value sampled at that edge.
